axi4_lite_rr_arbiter: RTL and testbench
=======================================

# axi4_lite_rr_arbiter

Two-master to one-slave AXI4-Lite arbiter that shares the AXI4-Lite slave memory block between two requesters. Write and read paths arbitrate independently, each round-robin. A grant is held from the address request until the response handshake completes. The block sits between the master VIP/RTL masters and the slave RTL in the example top.

## Interface
- DATA_WIDTH, 32, data bus width; STRB = DATA_WIDTH/8
- ADDRESS_WIDTH, 32, address bus width
- NUM_MASTERS, 2, fixed to 2 (vectors indexed [i], master i occupies slice i)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m_awvalid/m_awaddr in, m_awready out  2 / 2*ADDRESS_WIDTH / 2  per-master AW channel
- m_wvalid/m_wdata/m_wstrb in, m_wready out  2 / 2*DATA_WIDTH / 2*STRB / 2  per-master W channel
- m_bvalid/m_bresp out, m_bready in  2 / 4 / 2  per-master B channel
- m_arvalid/m_araddr in, m_arready out  2 / 2*ADDRESS_WIDTH / 2  per-master AR channel
- m_rvalid/m_rdata/m_rresp out, m_rready in  2 / 2*DATA_WIDTH / 4 / 2  per-master R channel
- s_aw*, s_w*, s_b*, s_ar*, s_r*  mirrored directions, single-width  slave-side AXI4-Lite port
- wr_grant, rd_grant  out  1 each  index of current owner (valid while busy)
- wr_grant_cnt, rd_grant_cnt  out  2*16 each  per-master grant counters (see Configuration)

## Operation
- Write FSM: WR_IDLE -> WR_BUSY -> WR_IDLE. Read FSM: RD_IDLE -> RD_BUSY -> RD_IDLE. Both FSMs are independent and may be busy concurrently, for the same master or for different masters.
- Write request i = m_awvalid[i] | m_wvalid[i]. Read request i = m_arvalid[i].
- In IDLE, when any request is present, register the grant and move to BUSY. Round-robin: the master after the last granted one wins ties. The pointer resets so that m0 wins the first tie.
- WR_BUSY forwarding is combinational:
  - Owner's AW and W drive s_aw*/s_w*. s_awready/s_wready return to the owner only. s_b* go to the owner only.
  - aw_done/w_done flags are set on their handshakes. Once a flag is set, the matching s_*valid is gated to 0.
  - Release on s_bvalid & s_bready, then return to WR_IDLE.
- RD_BUSY: same scheme for AR and R. ar_done gates s_arvalid. Release on s_rvalid & s_rready.
- Non-owner masters see ready=0 and valid=0 on all channels. When the FSM is idle, all slave-side valids and readies are 0 and data buses are 0.
- Responses (bresp/rresp) pass through unmodified. The arbiter never generates responses.

## Timing
- Arbitration latency: 1 cycle from request to first forwarded s_awvalid/s_arvalid.
- Re-arbitration: the earliest next grant is the cycle after release, so there is 1 dead cycle between back-to-back transactions.
- Slave holding bvalid while the owner holds bready=0: the grant is held indefinitely. The other master waits with awready=0.
- Both masters request in the same cycle: one grant only. The loser keeps valid asserted per AXI rules and is served next.
- Reset asserted mid-transaction: both FSMs go to IDLE asynchronously, every valid/ready output goes to 0, done flags clear, the pointer returns to favour m0, and counters clear.
- Output reset values: all m_*ready, m_*valid, s_*valid, s_*ready = 0; all data/resp/addr = 0; wr_grant = rd_grant = 0.

## Configuration
- AXI4_LITE_ARB_STATS_EN defined:
  - wr_grant_cnt[i] increments on each write grant to master i; rd_grant_cnt[i] likewise on each read grant.
  - Counters are 16-bit, saturate at 0xFFFF, and clear on reset.
- AXI4_LITE_ARB_STATS_EN undefined: the counters are not built and the ports are tied to 0.

## Structure
- Package axi4_lite_arb_pkg holds:
  - wr_state_t and rd_state_t enums
  - NUM_MASTERS
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - COUNTER_WIDTH = 16
- Sub-module axi4_lite_rr_pick holds the request vector, pointer register and registered winner index. It is instantiated once for write and once for read.

## Test plan
- m0 writes 0x0ABC0040 / 0xDEADBEEF / strb 0xF, slave returns bresp 00: s_awaddr = 0x0ABC0040 one cycle after awvalid; m_bresp[0] = 00; m1 sees no bvalid.
- m0 and m1 assert awvalid in the same cycle after reset: m0 is served first. m1 gets s_awvalid the cycle after m0's B handshake plus 1. Repeating the simultaneous request serves m0 first again (pointer follows m1).
- m0 writes 0x0ABC0100 while m1 reads 0x0BC00100: both FSMs are busy in overlapping cycles. Read data and rresp 00 reach only m1, and the write completes only to m0.
- m0 read with m_rready[0] low for 5 cycles after rvalid while m1 asserts arvalid: m_arready[1] = 0 throughout. m1's AR is forwarded 2 cycles after m0's R handshake.
- rst_n pulled low during W_BUSY with s_awvalid = 1: all outputs read 0 in the same cycle. After release, the first tie grants m0.
- With AXI4_LITE_ARB_STATS_EN, run 3 m0 writes, 2 m1 writes and 1 m1 read: wr_grant_cnt = {2,3}, rd_grant_cnt = {1,0}. Without the macro, all counters read 0.

Source files
------------

// File: rtl/axi4_lite_arb_pkg.sv
// rtl/axi4_lite_arb_pkg.sv - shared types and constants for the AXI4-Lite round-robin arbiter
package axi4_lite_arb_pkg;

  localparam int NUM_MASTERS   = 2;
  localparam int COUNTER_WIDTH = 16;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_BUSY = 1'b1
  } wr_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_BUSY = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_rr_pick.sv
// rtl/axi4_lite_rr_pick.sv - two-way round-robin picker with registered winner index
module axi4_lite_rr_pick
  import axi4_lite_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   en,
  output logic                   take,
  output logic                   winner,
  output logic                   grant
);

  // Index of the most recent grant; resets to 1 so master 0 wins the first tie.
  logic last;
  logic next_idx;

  // The master after the last winner has priority; otherwise the sole requester wins.
  always_comb begin
    next_idx = ~last;
    winner   = req[next_idx] ? next_idx : last;
    take     = en & (|req);
  end

  // Capture the winner whenever the owning FSM accepts a new request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last  <= 1'b1;
      grant <= 1'b0;
    end else if (take) begin
      last  <= winner;
      grant <= winner;
    end
  end

endmodule

// File: rtl/axi4_lite_rr_arbiter.sv
// rtl/axi4_lite_rr_arbiter.sv - 2:1 AXI4-Lite arbiter, independent round-robin write/read paths; AXI4_LITE_ARB_STATS_EN enables grant counters
module axi4_lite_rr_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter  int DATA_WIDTH    = 32,
  parameter  int ADDRESS_WIDTH = 32,
  localparam int STRB          = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    m_awvalid,
  input  logic [2*ADDRESS_WIDTH-1:0]    m_awaddr,
  output logic [1:0]                    m_awready,
  input  logic [1:0]                    m_wvalid,
  input  logic [2*DATA_WIDTH-1:0]       m_wdata,
  input  logic [2*STRB-1:0]             m_wstrb,
  output logic [1:0]                    m_wready,
  output logic [1:0]                    m_bvalid,
  output logic [3:0]                    m_bresp,
  input  logic [1:0]                    m_bready,
  input  logic [1:0]                    m_arvalid,
  input  logic [2*ADDRESS_WIDTH-1:0]    m_araddr,
  output logic [1:0]                    m_arready,
  output logic [1:0]                    m_rvalid,
  output logic [2*DATA_WIDTH-1:0]       m_rdata,
  output logic [3:0]                    m_rresp,
  input  logic [1:0]                    m_rready,
  output logic                          s_awvalid,
  output logic [ADDRESS_WIDTH-1:0]      s_awaddr,
  input  logic                          s_awready,
  output logic                          s_wvalid,
  output logic [DATA_WIDTH-1:0]         s_wdata,
  output logic [STRB-1:0]               s_wstrb,
  input  logic                          s_wready,
  input  logic                          s_bvalid,
  input  logic [1:0]                    s_bresp,
  output logic                          s_bready,
  output logic                          s_arvalid,
  output logic [ADDRESS_WIDTH-1:0]      s_araddr,
  input  logic                          s_arready,
  input  logic                          s_rvalid,
  input  logic [DATA_WIDTH-1:0]         s_rdata,
  input  logic [1:0]                    s_rresp,
  output logic                          s_rready,
  output logic                          wr_grant,
  output logic                          rd_grant,
  output logic [2*COUNTER_WIDTH-1:0]    wr_grant_cnt,
  output logic [2*COUNTER_WIDTH-1:0]    rd_grant_cnt
);

  wr_state_t wr_state;
  rd_state_t rd_state;
  logic      aw_done, w_done, ar_done;
  logic      wr_take, wr_winner, rd_take, rd_winner;

  axi4_lite_rr_pick u_wr_pick (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (m_awvalid | m_wvalid),
    .en     (wr_state == WR_IDLE),
    .take   (wr_take),
    .winner (wr_winner),
    .grant  (wr_grant)
  );

  axi4_lite_rr_pick u_rd_pick (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (m_arvalid),
    .en     (rd_state == RD_IDLE),
    .take   (rd_take),
    .winner (rd_winner),
    .grant  (rd_grant)
  );

  // Write ownership: hold the grant from request until the B handshake, tracking AW/W completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state <= WR_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (wr_take) wr_state <= WR_BUSY;
        end
        WR_BUSY: begin
          if (s_awvalid && s_awready) aw_done <= 1'b1;
          if (s_wvalid && s_wready)   w_done  <= 1'b1;
          if (s_bvalid && s_bready) begin
            wr_state <= WR_IDLE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read ownership: hold the grant from request until the R handshake, tracking AR completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      ar_done  <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          ar_done <= 1'b0;
          if (rd_take) rd_state <= RD_BUSY;
        end
        RD_BUSY: begin
          if (s_arvalid && s_arready) ar_done <= 1'b1;
          if (s_rvalid && s_rready) begin
            rd_state <= RD_IDLE;
            ar_done  <= 1'b0;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // Write-path crossbar: only the owner is connected; everything else is held at zero.
  always_comb begin
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    if (wr_state == WR_BUSY) begin
      s_awvalid = m_awvalid[wr_grant] & ~aw_done;
      s_wvalid  = m_wvalid[wr_grant] & ~w_done;
      s_bready  = m_bready[wr_grant];
      s_awaddr  = wr_grant ? m_awaddr[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH] : m_awaddr[ADDRESS_WIDTH-1:0];
      s_wdata   = wr_grant ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];
      s_wstrb   = wr_grant ? m_wstrb[2*STRB-1:STRB] : m_wstrb[STRB-1:0];
      m_awready[wr_grant] = s_awready & ~aw_done;
      m_wready[wr_grant]  = s_wready & ~w_done;
      m_bvalid[wr_grant]  = s_bvalid;
      if (wr_grant) m_bresp[3:2] = s_bresp;
      else          m_bresp[1:0] = s_bresp;
    end
  end

  // Read-path crossbar: only the owner is connected; everything else is held at zero.
  always_comb begin
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_rready  = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    if (rd_state == RD_BUSY) begin
      s_arvalid = m_arvalid[rd_grant] & ~ar_done;
      s_rready  = m_rready[rd_grant];
      s_araddr  = rd_grant ? m_araddr[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH] : m_araddr[ADDRESS_WIDTH-1:0];
      m_arready[rd_grant] = s_arready & ~ar_done;
      m_rvalid[rd_grant]  = s_rvalid;
      if (rd_grant) begin
        m_rdata[2*DATA_WIDTH-1:DATA_WIDTH] = s_rdata;
        m_rresp[3:2] = s_rresp;
      end else begin
        m_rdata[DATA_WIDTH-1:0] = s_rdata;
        m_rresp[1:0] = s_rresp;
      end
    end
  end

`ifdef AXI4_LITE_ARB_STATS_EN
  logic [COUNTER_WIDTH-1:0] wr_cnt [NUM_MASTERS];
  logic [COUNTER_WIDTH-1:0] rd_cnt [NUM_MASTERS];

  // Saturating per-master grant counters, bumped when a grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt[0] <= '0;
      wr_cnt[1] <= '0;
      rd_cnt[0] <= '0;
      rd_cnt[1] <= '0;
    end else begin
      if (wr_take && (wr_cnt[wr_winner] != '1)) wr_cnt[wr_winner] <= wr_cnt[wr_winner] + 1'b1;
      if (rd_take && (rd_cnt[rd_winner] != '1)) rd_cnt[rd_winner] <= rd_cnt[rd_winner] + 1'b1;
    end
  end

  assign wr_grant_cnt = {wr_cnt[1], wr_cnt[0]};
  assign rd_grant_cnt = {rd_cnt[1], rd_cnt[0]};
`else
  // Winner indices only feed the counters; without them they are intentionally dropped.
  logic unused_winner;
  assign unused_winner = wr_winner ^ rd_winner;
  assign wr_grant_cnt  = '0;
  assign rd_grant_cnt  = '0;
`endif

endmodule

// File: tb/tb_axi4_lite_rr_arbiter.sv
// tb/tb_axi4_lite_rr_arbiter.sv - self-checking bench for axi4_lite_rr_arbiter
module tb_axi4_lite_rr_arbiter;
  import axi4_lite_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [7:0]  m_wstrb;
  logic [3:0]  m_bresp, m_rresp;
  logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        wr_grant, rd_grant;
  logic [31:0] wr_grant_cnt, rd_grant_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int last_wr, last_rd;
  int exp_wcnt [2];
  int exp_rcnt [2];
  logic [31:0] exp_awaddr [2];
  logic [31:0] exp_wdata [2];
  logic [3:0]  exp_wstrb [2];
  logic [31:0] exp_araddr [2];

  axi4_lite_rr_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rready(m_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
    .wr_grant(wr_grant), .rd_grant(rd_grant),
    .wr_grant_cnt(wr_grant_cnt), .rd_grant_cnt(rd_grant_cnt)
  );

  always #5 clk = ~clk;

  function automatic int rr_winner(input logic [1:0] req, input int last);
    if (req == 2'b11) return 1 - last;
    return req[1] ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr_req(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    m_awvalid[m] = 1'b1;
    m_wvalid[m]  = 1'b1;
    m_awaddr[m*32 +: 32] = a;
    m_wdata[m*32 +: 32]  = d;
    m_wstrb[m*4 +: 4]    = s;
    exp_awaddr[m] = a;
    exp_wdata[m]  = d;
    exp_wstrb[m]  = s;
  endtask

  task automatic set_rd_req(input int m, input logic [31:0] a);
    m_arvalid[m] = 1'b1;
    m_araddr[m*32 +: 32] = a;
    exp_araddr[m] = a;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m_awvalid = '0; m_awaddr = '0; m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_bready = '0;
    m_arvalid = '0; m_araddr = '0; m_rready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    repeat (3) step();
    rst_n = 1'b1;
    last_wr = 1; last_rd = 1;
    exp_wcnt[0] = 0; exp_wcnt[1] = 0; exp_rcnt[0] = 0; exp_rcnt[1] = 0;
  endtask

  function automatic logic [252:0] all_outputs();
    return {m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp,
            s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready, s_arvalid, s_araddr,
            s_rready, wr_grant, rd_grant, wr_grant_cnt, rd_grant_cnt};
  endfunction

  // Drive one write for the expected owner through the slave side and check routing.
  task automatic wr_txn(input int who, input logic [1:0] resp, input int bhold, output int lat);
    logic [1:0] oh;
    logic [3:0] rsp4;
    oh   = (who == 1) ? 2'b10 : 2'b01;
    rsp4 = (who == 1) ? {resp, 2'b00} : {2'b00, resp};
    lat  = 0;
    #1;
    while (s_awvalid !== 1'b1 && lat < 8) begin step(); lat++; end
    n_cmp++;
    if (s_awvalid !== 1'b1) begin n_err++; $display("FAIL wr_wait_awvalid: got %b want 1", s_awvalid); end
    n_cmp++;
    if (wr_grant !== oh[1]) begin n_err++; $display("FAIL wr_grant: got %b want %b", wr_grant, oh[1]); end
    n_cmp++;
    if ({s_awaddr, s_wdata, s_wstrb, s_wvalid} !== {exp_awaddr[who], exp_wdata[who], exp_wstrb[who], 1'b1}) begin
      n_err++;
      $display("FAIL wr_forward: got %h/%h/%h want %h/%h/%h", s_awaddr, s_wdata, s_wstrb,
               exp_awaddr[who], exp_wdata[who], exp_wstrb[who]);
    end
    s_awready = 1'b1; s_wready = 1'b1;
    #1;
    n_cmp++;
    if ({m_awready, m_wready} !== {oh, oh}) begin
      n_err++; $display("FAIL wr_ready_route: got %b/%b want %b/%b", m_awready, m_wready, oh, oh);
    end
    step();
    s_awready = 1'b0; s_wready = 1'b0;
    #1;
    n_cmp++;
    if ({s_awvalid, s_wvalid} !== 2'b00) begin
      n_err++; $display("FAIL wr_done_gate: got %b want 00", {s_awvalid, s_wvalid});
    end
    m_awvalid[who] = 1'b0; m_wvalid[who] = 1'b0;
    s_bvalid = 1'b1; s_bresp = resp; m_bready[who] = 1'b0;
    #1;
    for (int k = 0; k < bhold; k++) begin
      n_cmp++;
      if ({m_bvalid, m_awready, s_bready} !== {oh, 2'b00, 1'b0}) begin
        n_err++; $display("FAIL wr_bhold: got bvalid=%b awready=%b bready=%b want %b/00/0", m_bvalid, m_awready, s_bready, oh);
      end
      step();
    end
    m_bready[who] = 1'b1;
    #1;
    n_cmp++;
    if ({m_bvalid, m_bresp, s_bready} !== {oh, rsp4, 1'b1}) begin
      n_err++; $display("FAIL wr_bresp_route: got %b/%b/%b want %b/%b/1", m_bvalid, m_bresp, s_bready, oh, rsp4);
    end
    step();
    s_bvalid = 1'b0; s_bresp = '0; m_bready[who] = 1'b0;
    last_wr = who;
    exp_wcnt[who]++;
  endtask

  // Drive one read for the expected owner through the slave side and check routing.
  task automatic rd_txn(input int who, input logic [1:0] resp, input int rhold, output int lat);
    logic [1:0]  oh;
    logic [3:0]  rsp4;
    logic [31:0] d;
    logic [63:0] d64;
    d    = $urandom;
    oh   = (who == 1) ? 2'b10 : 2'b01;
    rsp4 = (who == 1) ? {resp, 2'b00} : {2'b00, resp};
    d64  = (who == 1) ? {d, 32'h0} : {32'h0, d};
    lat  = 0;
    #1;
    while (s_arvalid !== 1'b1 && lat < 8) begin step(); lat++; end
    n_cmp++;
    if (s_arvalid !== 1'b1) begin n_err++; $display("FAIL rd_wait_arvalid: got %b want 1", s_arvalid); end
    n_cmp++;
    if ({rd_grant, s_araddr} !== {oh[1], exp_araddr[who]}) begin
      n_err++; $display("FAIL rd_forward: got %b/%h want %b/%h", rd_grant, s_araddr, oh[1], exp_araddr[who]);
    end
    s_arready = 1'b1;
    #1;
    n_cmp++;
    if (m_arready !== oh) begin n_err++; $display("FAIL rd_arready_route: got %b want %b", m_arready, oh); end
    step();
    s_arready = 1'b0;
    #1;
    n_cmp++;
    if (s_arvalid !== 1'b0) begin n_err++; $display("FAIL rd_done_gate: got %b want 0", s_arvalid); end
    m_arvalid[who] = 1'b0;
    s_rvalid = 1'b1; s_rdata = d; s_rresp = resp; m_rready[who] = 1'b0;
    #1;
    for (int k = 0; k < rhold; k++) begin
      n_cmp++;
      if ({m_rvalid, m_arready, s_rready} !== {oh, 2'b00, 1'b0}) begin
        n_err++; $display("FAIL rd_rhold: got rvalid=%b arready=%b rready=%b want %b/00/0", m_rvalid, m_arready, s_rready, oh);
      end
      step();
    end
    m_rready[who] = 1'b1;
    #1;
    n_cmp++;
    if ({m_rvalid, m_rdata, m_rresp, s_rready} !== {oh, d64, rsp4, 1'b1}) begin
      n_err++; $display("FAIL rd_data_route: got %b/%h/%b/%b want %b/%h/%b/1", m_rvalid, m_rdata, m_rresp, s_rready, oh, d64, rsp4);
    end
    step();
    s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0; m_rready[who] = 1'b0;
    last_rd = who;
    exp_rcnt[who]++;
  endtask

  task automatic check_counters(input string tag);
    logic [31:0] ew, er;
`ifdef AXI4_LITE_ARB_STATS_EN
    ew = {16'(exp_wcnt[1]), 16'(exp_wcnt[0])};
    er = {16'(exp_rcnt[1]), 16'(exp_rcnt[0])};
`else
    ew = '0;
    er = '0;
`endif
    n_cmp++;
    if ({wr_grant_cnt, rd_grant_cnt} !== {ew, er}) begin
      n_err++; $display("FAIL counters_%s: got wr=%h rd=%h want wr=%h rd=%h", tag, wr_grant_cnt, rd_grant_cnt, ew, er);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_outputs() !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", all_outputs()); end
    apply_reset();
    #1;
    n_cmp++;
    if (all_outputs() !== '0) begin n_err++; $display("FAIL post_reset_idle: got %h want 0", all_outputs()); end
  endtask

  task automatic test_single_write();
    int lat;
    set_wr_req(0, 32'h0ABC0040, 32'hDEADBEEF, 4'hF);
    wr_txn(0, RESP_OKAY, 0, lat);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL single_write_latency: got %0d want 1", lat); end
  endtask

  task automatic test_round_robin();
    int lat, w;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      set_wr_req(0, $urandom, $urandom, 4'($urandom));
      set_wr_req(1, $urandom, $urandom, 4'($urandom));
      w = rr_winner(2'b11, last_wr);
      wr_txn(w, RESP_OKAY, 1, lat);
      wr_txn(1 - w, RESP_SLVERR, 0, lat);
      n_cmp++;
      if (lat !== 1) begin n_err++; $display("FAIL rr_dead_cycle: got %0d want 1", lat); end
    end
  endtask

  task automatic test_concurrent();
    int lat;
    set_wr_req(0, 32'h0ABC0100, $urandom, 4'hF);
    set_rd_req(1, 32'h0BC00100);
    #1;
    step();
    n_cmp++;
    if ({s_awvalid, s_arvalid, wr_grant, rd_grant} !== 4'b1101) begin
      n_err++; $display("FAIL concurrent_busy: got %b want 1101", {s_awvalid, s_arvalid, wr_grant, rd_grant});
    end
    wr_txn(0, RESP_OKAY, 1, lat);
    rd_txn(1, RESP_OKAY, 0, lat);
  endtask

  task automatic test_read_hold();
    int lat;
    set_rd_req(0, $urandom);
    #1;
    step();
    set_rd_req(1, $urandom);
    rd_txn(0, RESP_OKAY, 5, lat);
    rd_txn(1, RESP_OKAY, 0, lat);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL read_rearb_latency: got %0d want 1", lat); end
  endtask

  task automatic test_reset_mid();
    int lat, w;
    set_wr_req(0, $urandom, $urandom, 4'hF);
    wr_txn(0, RESP_OKAY, 0, lat);
    set_wr_req(0, $urandom, $urandom, 4'hF);
    set_rd_req(1, $urandom);
    #1;
    step();
    n_cmp++;
    if ({s_awvalid, s_arvalid} !== 2'b11) begin n_err++; $display("FAIL mid_busy: got %b want 11", {s_awvalid, s_arvalid}); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_outputs() !== '0) begin n_err++; $display("FAIL mid_reset_outputs: got %h want 0", all_outputs()); end
    step();
    step();
    rst_n = 1'b1;
    last_wr = 1; last_rd = 1;
    exp_wcnt[0] = 0; exp_wcnt[1] = 0; exp_rcnt[0] = 0; exp_rcnt[1] = 0;
    check_counters("after_reset");
    set_wr_req(1, $urandom, $urandom, 4'h3);
    w = rr_winner(2'b11, last_wr);
    wr_txn(w, RESP_OKAY, 0, lat);
    wr_txn(1 - w, RESP_OKAY, 0, lat);
    rd_txn(1, RESP_OKAY, 0, lat);
  endtask

  task automatic test_random();
    int lat, w;
    logic [1:0] req;
    for (int it = 0; it < 20; it++) begin
      req = 2'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++)
        if (req[m]) set_wr_req(m, $urandom, $urandom, 4'($urandom));
      w = rr_winner(req, last_wr);
      wr_txn(w, ($urandom_range(0, 1) != 0) ? RESP_SLVERR : RESP_OKAY, $urandom_range(0, 3), lat);
      if (req == 2'b11) wr_txn(1 - w, RESP_OKAY, $urandom_range(0, 3), lat);
      req = 2'($urandom_range(1, 3));
      for (int m = 0; m < 2; m++)
        if (req[m]) set_rd_req(m, $urandom);
      w = rr_winner(req, last_rd);
      rd_txn(w, ($urandom_range(0, 1) != 0) ? RESP_SLVERR : RESP_OKAY, $urandom_range(0, 3), lat);
      if (req == 2'b11) rd_txn(1 - w, RESP_OKAY, $urandom_range(0, 3), lat);
    end
    check_counters("random");
  endtask

  task automatic test_stats();
    int lat;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      set_wr_req(0, $urandom, $urandom, 4'hF);
      wr_txn(0, RESP_OKAY, 0, lat);
    end
    for (int k = 0; k < 2; k++) begin
      set_wr_req(1, $urandom, $urandom, 4'hF);
      wr_txn(1, RESP_OKAY, 0, lat);
    end
    set_rd_req(1, $urandom);
    rd_txn(1, RESP_OKAY, 0, lat);
    check_counters("stats");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_concurrent();
    test_read_hold();
    test_reset_mid();
    test_random();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
